seg_scan_decoder: RTL and testbench

Reads a multiplexed 7-segment display bus, consisting of segment lines plus a one-hot digit select, and reconstructs the displayed hex value. It is the receive end of the hex-to-segment path: it decodes segment patterns back to nibbles and assembles a full multi-digit frame. It sits between the display drive lines and the self-check / loopback logic. Each digit pattern must be stable for a configurable number of cycles before it is accepted.

---
 rtl/seg_pkg.sv | 62 ++++++
 rtl/seg_scan_decoder_if.sv | 22 ++
 rtl/seg_pattern_decode.sv | 20 ++
 rtl/seg_scan_decoder.sv | 134 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Segment bit positions, the shared hex glyph table and its inverse lookup,
// used by both the segment encoder and the scan decoder.
package seg_pkg;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HELD
  } run_state_e;

  // Returns {valid, nibble}; dp is ignored. Unknown patterns give {0, 4'h0}.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [7:0] glyph;
    glyph = pat & 8'hFE;
    case (glyph)
      GLYPH_0: seg_decode = {1'b1, 4'h0};
      GLYPH_1: seg_decode = {1'b1, 4'h1};
      GLYPH_2: seg_decode = {1'b1, 4'h2};
      GLYPH_3: seg_decode = {1'b1, 4'h3};
      GLYPH_4: seg_decode = {1'b1, 4'h4};
      GLYPH_5: seg_decode = {1'b1, 4'h5};
      GLYPH_6: seg_decode = {1'b1, 4'h6};
      GLYPH_7: seg_decode = {1'b1, 4'h7};
      GLYPH_8: seg_decode = {1'b1, 4'h8};
      GLYPH_9: seg_decode = {1'b1, 4'h9};
      GLYPH_A: seg_decode = {1'b1, 4'hA};
      GLYPH_B: seg_decode = {1'b1, 4'hB};
      GLYPH_C: seg_decode = {1'b1, 4'hC};
      GLYPH_D: seg_decode = {1'b1, 4'hD};
      GLYPH_E: seg_decode = {1'b1, 4'hE};
      GLYPH_F: seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed display bus plus the reconstructed-frame outputs of the scan decoder.
interface seg_scan_decoder_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic [7:0]              seg_in;
  logic [N_DIGITS-1:0]     dig_sel;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_out;
  logic [N_DIGITS-1:0]     err_out;
  logic                    frame_valid;
  logic                    sel_err;

  modport master (
    output seg_in, dig_sel,
    input  value, dp_out, err_out, frame_valid, sel_err
  );

  modport slave (
    input  seg_in, dig_sel,
    output value, dp_out, err_out, frame_valid, sel_err
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to nibble decode with dp extraction and illegal-glyph flag.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       err
);

  logic [4:0] dec;

  always_comb begin
    dec    = seg_decode(pattern);
    nibble = dec[3:0];
    dp     = pattern[SEG_DP];
    err    = ~dec[4];
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receives a multiplexed 7-segment bus, debounces each digit, and assembles
// complete multi-digit frames of hex nibbles, dp and illegal-glyph flags.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus
);

  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IW = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [7:0]                seg_q, seg_p;
  logic [N_DIGITS-1:0]       sel_q, sel_p;
  logic [CW-1:0]             cnt, cnt_n;
  run_state_e                state, state_n;
  logic                      accept;
  logic                      onehot, multi, same;
  logic [IW-1:0]             idx;
  logic [N_DIGITS-1:0]       seen, seen_n, acc_mask;
  logic                      load_q;
  logic [N_DIGITS-1:0][3:0]  shadow_nib;
  logic [N_DIGITS-1:0]       shadow_dp, shadow_err;
  logic [3:0]                dec_nib;
  logic                      dec_dp, dec_err;

  seg_pattern_decode u_dec (
    .pattern (seg_q),
    .nibble  (dec_nib),
    .dp      (dec_dp),
    .err     (dec_err)
  );

  always_comb begin
    onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    multi  = (sel_q != '0) && !onehot;
    same   = (sel_q == sel_p) && (seg_q == seg_p);
    idx    = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (sel_q[i]) idx = IW'(i);
    end
  end

  // ST_HELD marks a run that already reached the count; it blocks re-accept until the run breaks.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (!onehot) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else if (same && state != ST_IDLE) begin
      if (state == ST_RUN) begin
        if (cnt == CNT_MAX - 1'b1) begin
          cnt_n   = CNT_MAX;
          state_n = ST_HELD;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end else begin
      cnt_n = CW'(1);
      if (STABLE_CYCLES == 1) begin
        state_n = ST_HELD;
        accept  = 1'b1;
      end else begin
        state_n = ST_RUN;
      end
    end
  end

  always_comb begin
    acc_mask = accept ? sel_q : '0;
    seen_n   = seen | acc_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '0;
      sel_q       <= '0;
      seg_p       <= '0;
      sel_p       <= '0;
      state       <= ST_IDLE;
      cnt         <= '0;
      seen        <= '0;
      load_q      <= 1'b0;
      shadow_nib  <= '0;
      shadow_dp   <= '0;
      shadow_err  <= '0;
      bus.value       <= '0;
      bus.dp_out      <= '0;
      bus.err_out     <= '0;
      bus.frame_valid <= 1'b0;
      bus.sel_err     <= 1'b0;
    end else begin
      seg_q <= bus.seg_in;
      sel_q <= bus.dig_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
      state <= state_n;
      cnt   <= cnt_n;
      bus.sel_err <= multi;

      if (accept) begin
        shadow_nib[idx] <= dec_nib;
        shadow_dp[idx]  <= dec_dp;
        shadow_err[idx] <= dec_err;
      end

      // Completion is latched here and loaded next edge, after the final accept lands in shadow.
      if (accept && (&seen_n)) begin
        seen   <= '0;
        load_q <= 1'b1;
      end else begin
        seen   <= seen_n;
        load_q <= 1'b0;
      end

      bus.frame_valid <= load_q;
      if (load_q) begin
        bus.value   <= shadow_nib;
        bus.dp_out  <= shadow_dp;
        bus.err_out <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed-vector bench for seg_scan_decoder with N_DIGITS=4, STABLE_CYCLES=4.
module tb_seg_scan_decoder;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   fv_cnt   = 0;
  int   se_cnt   = 0;

  always #5 clk = ~clk;

  seg_scan_decoder_if #(.N_DIGITS(N)) bus ();

  seg_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.sel_err) se_cnt++;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] pat, input int n);
    bus.dig_sel = sel;
    bus.seg_in  = pat;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    fv_cnt = 0;
    se_cnt = 0;
  endtask

  initial begin
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_value", 32'(bus.value), 32'h0);
    check_eq("rst_dp", 32'(bus.dp_out), 32'h0);
    check_eq("rst_err", 32'(bus.err_out), 32'h0);
    check_eq("rst_fv", 32'(bus.frame_valid), 32'h0);
    check_eq("rst_selerr", 32'(bus.sel_err), 32'h0);

    // Basic frame
    clear_counts();
    drive(4'b0001, 8'hF2, 6);
    drive(4'b0010, 8'h66, 6);
    drive(4'b0100, 8'hEE, 6);
    drive(4'b1000, 8'h8E, 6);
    drive(4'b0000, 8'h00, 4);
    check_eq("basic_fv_cnt", 32'(fv_cnt), 32'd1);
    check_eq("basic_value", 32'(bus.value), 32'hFA43);
    check_eq("basic_err", 32'(bus.err_out), 32'h0);
    check_eq("basic_dp", 32'(bus.dp_out), 32'h0);

    // Glitch rejection; digits 1..3 held exactly STABLE_CYCLES samples
    clear_counts();
    drive(4'b0001, 8'hB6, 3);
    drive(4'b0001, 8'hFC, 6);
    drive(4'b0010, 8'h60, 4);
    drive(4'b0100, 8'h60, 4);
    drive(4'b1000, 8'h60, 4);
    drive(4'b0000, 8'h00, 4);
    check_eq("glitch_fv_cnt", 32'(fv_cnt), 32'd1);
    check_eq("glitch_value", 32'(bus.value), 32'h1110);

    // Illegal glyph and dp
    clear_counts();
    drive(4'b0001, 8'hFE, 6);
    drive(4'b0010, 8'hFE, 6);
    drive(4'b0100, 8'h01, 6);
    drive(4'b1000, 8'hFE, 6);
    drive(4'b0000, 8'h00, 4);
    check_eq("illegal_fv_cnt", 32'(fv_cnt), 32'd1);
    check_eq("illegal_value", 32'(bus.value), 32'h8088);
    check_eq("illegal_err", 32'(bus.err_out), 32'h4);
    check_eq("illegal_dp", 32'(bus.dp_out), 32'h4);

    // Select faults
    clear_counts();
    drive(4'b0110, 8'hFE, 5);
    drive(4'b0000, 8'hFE, 3);
    check_eq("multisel_selerr_cnt", 32'(se_cnt), 32'd5);
    check_eq("multisel_fv_cnt", 32'(fv_cnt), 32'd0);
    check_eq("multisel_value", 32'(bus.value), 32'h8088);
    clear_counts();
    drive(4'b0000, 8'hFE, 10);
    check_eq("blank_selerr_cnt", 32'(se_cnt), 32'd0);
    check_eq("blank_fv_cnt", 32'(fv_cnt), 32'd0);

    // Overwrite within a frame: latest accept wins
    clear_counts();
    drive(4'b0010, 8'h60, 6);
    drive(4'b0010, 8'hDA, 6);
    drive(4'b0001, 8'hFC, 6);
    drive(4'b0100, 8'hE0, 6);
    drive(4'b1000, 8'hF6, 6);
    drive(4'b0000, 8'h00, 4);
    check_eq("overwrite_fv_cnt", 32'(fv_cnt), 32'd1);
    check_eq("overwrite_value", 32'(bus.value), 32'h9720);

    // Reset mid-frame discards partial progress
    clear_counts();
    drive(4'b0001, 8'hFC, 6);
    drive(4'b0010, 8'h60, 6);
    bus.dig_sel = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_value_now", 32'(bus.value), 32'h0);
    drive(4'b0100, 8'hDA, 6);
    drive(4'b1000, 8'hF2, 6);
    drive(4'b0000, 8'h00, 6);
    check_eq("midrst_fv_cnt", 32'(fv_cnt), 32'd0);
    check_eq("midrst_value", 32'(bus.value), 32'h0);
    check_eq("midrst_dp", 32'(bus.dp_out), 32'h0);
    check_eq("midrst_err", 32'(bus.err_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
